bitwise_reduce_acc: RTL and testbench
=====================================

// Module: bitwise_reduce_acc
// PURPOSE
// - Streaming, parametrised successor to the two-input AND primitive: reduces a burst of WIDTH-bit
//   beats to one WIDTH-bit word with a selectable bitwise op (AND/OR/XOR/NAND).
// - Sits between a valid/ready producer and consumer; returns result, beat count, overflow flag.
// PARAMETERS
// - WIDTH      8   data width of each beat and of the result
// - MAX_BEATS  16  max beats folded per burst (>=1); CW = $clog2(MAX_BEATS+1)
// PORTS
// - clk           in   1      single clock, rising edge
// - rst           in   1      asynchronous, active-high reset
// - op            in   2      00 AND, 01 OR, 10 XOR, 11 NAND; sampled with first beat of burst
// - in_valid      in   1      input beat valid
// - in_ready      out  1      block accepts beat when in_valid & in_ready
// - in_data       in   WIDTH  beat data
// - in_last       in   1      final beat of burst
// - out_valid     out  1      result valid
// - out_ready     in   1      consumer accepts result when out_valid & out_ready
// - out_data      out  WIDTH  reduced result
// - out_beats     out  CW     beats folded into out_data (1..MAX_BEATS)
// - out_overflow  out  1      burst exceeded MAX_BEATS; extra beats discarded
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, acc=0, count=0, op_q=AND, overflow=0, out_valid=0,
//   out_data=0, out_beats=0, out_overflow=0, in_ready=1 on first cycle after release.
// - FSM states IDLE, ACC, DRAIN, DONE. in_ready=1 in IDLE/ACC/DRAIN, 0 in DONE. out_valid=1 only in DONE.
// - IDLE, beat accepted: op_q<=op, acc<=in_data, count<=1, overflow<=0.
//   in_last -> DONE; else count==MAX_BEATS -> DRAIN with overflow<=1; else -> ACC.
// - ACC, beat accepted: acc<=acc OP in_data (NAND folds as AND), count<=count+1.
//   in_last -> DONE; else new count==MAX_BEATS -> DRAIN, overflow<=1; else stay.
// - MAX_BEATS-th beat carrying in_last -> DONE with overflow=0 (exact fit is not overflow).
// - DRAIN: beats accepted and discarded; acc/count frozen; in_last beat -> DONE.
// - DONE: out_data = (op_q==NAND) ? ~acc : acc; out_beats=count; out_overflow=overflow.
//   Outputs stable while out_valid & !out_ready. On handshake -> IDLE next cycle.
// - Latency: out_valid asserts the cycle after the in_last beat handshake; one burst in flight
//   (no overlap; next burst's first beat accepted earliest the cycle after result handshake).
// - op changes mid-burst are ignored; in_data/in_last ignored when in_valid=0.
// - Cycles with in_valid=0 in ACC/DRAIN hold state; no timeout.
// - Reset mid-burst or mid-DONE discards partial result; no out_valid pulse emitted.
// - Arithmetic: count saturates at MAX_BEATS (CW bits never wrap); ops purely bitwise, no carry.
// STRUCTURE
// - Package bitwise_reduce_pkg: op_e enum (OP_AND, OP_OR, OP_XOR, OP_NAND),
//   state_e enum (S_IDLE, S_ACC, S_DRAIN, S_DONE).
// - Sub-module bitwise_op_unit #(WIDTH): combinational a OP b for op_e (NAND mapped to AND);
//   one instance feeds acc next-value. FSM, counter, output mux stay in top.
// TESTING (WIDTH=8, MAX_BEATS=4 unless stated)
// - Single beat AND A5 last -> next cycle out_valid=1, out_data=A5, out_beats=1, out_overflow=0.
// - AND F0,3C,FF (last on 3rd) -> out_data=30, out_beats=3; XOR 0F,F0 -> FF; OR 01,80 -> 81.
// - NAND FF,FF -> out_data=00, beats=2; NAND F0,0F -> FF; op flipped to XOR on beat 2 -> ignored.
// - 6-beat AND 11,33,77,FF,00,00 (last on 6th) -> out_data=11, out_beats=4, out_overflow=1;
//   exactly 4 beats with last on 4th -> overflow=0.
// - out_ready low 5 cycles in DONE -> out_valid/out_data/out_beats stable, in_ready=0 throughout;
//   in_valid gaps mid-burst -> same result as gap-free burst.
// - rst pulsed after 2 beats of a burst -> all outputs 0 immediately; fresh burst OR 0A last -> 0A, beats=1.

Source files
------------

// File: rtl/bitwise_reduce_pkg.sv
// Shared types for the bitwise burst reducer: fold operators and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bitwise_reduce_pkg;

    // Fold operator. Encoding matches the 2-bit op port.
    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    // Burst lifecycle: waiting, folding, discarding excess beats, holding a result.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACC   = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/bitwise_op_unit.sv
// Combinational bitwise fold of two words for the selected operator.
// Latency: zero cycles (pure combinational).
// Backpressure: none, no handshake.
module bitwise_op_unit
    import bitwise_reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // NAND folds as AND; the final inversion is applied once on the result path.
    always_comb begin
        y = a & b;
        case (op)
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = a & b;
        endcase
    end

endmodule

// File: rtl/bitwise_reduce_acc.sv
// Folds a valid/ready burst of WIDTH-bit beats into one word (AND/OR/XOR/NAND), with beat count and overflow.
// Latency: result valid the cycle after the in_last handshake; one burst in flight at a time.
// Backpressure: in_ready drops while a result waits; the result holds stable until out_ready.
module bitwise_reduce_acc
    import bitwise_reduce_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  MAX_BEATS = 16,
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_beats,
    output logic             out_overflow
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    op_e              op_q, op_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [WIDTH-1:0] fold;
    logic [CW-1:0]    count_inc;

    assign accept    = in_valid & in_ready;
    // Only used from ACC, where count_q < MAX_BEATS, so this never wraps.
    assign count_inc = count_q + ONE_CNT;

    bitwise_op_unit #(
        .WIDTH (WIDTH)
    ) u_op (
        .op (op_q),
        .a  (acc_q),
        .b  (in_data),
        .y  (fold)
    );

    // State and datapath registers; reset discards any partial or pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            op_q    <= OP_AND;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update; the last beat always wins over the overflow check.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op_e'(op);
                    acc_d   = in_data;
                    count_d = ONE_CNT;
                    ovf_d   = 1'b0;
                    if (in_last) begin
                        state_d = S_DONE;
                    end else if (ONE_CNT == MAX_CNT) begin
                        state_d = S_DRAIN;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d   = fold;
                    count_d = count_inc;
                    if (in_last) begin
                        state_d = S_DONE;
                    end else if (count_inc == MAX_CNT) begin
                        state_d = S_DRAIN;
                        ovf_d   = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && in_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready     = (state_q != S_DONE);
    assign out_valid    = (state_q == S_DONE);
    assign out_data     = out_valid ? ((op_q == OP_NAND) ? ~acc_q : acc_q) : '0;
    assign out_beats    = out_valid ? count_q : '0;
    assign out_overflow = out_valid & ovf_q;

endmodule

// File: tb/tb_bitwise_reduce_acc.sv
module tb_bitwise_reduce_acc;

    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 4;
    localparam int CW        = $clog2(MAX_BEATS + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       op = 2'b00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_beats;
    logic             out_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitwise_reduce_acc #(
        .WIDTH     (WIDTH),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_beats    (out_beats),
        .out_overflow (out_overflow)
    );

    // Beats packed first-beat-in-the-top-byte so literals read left to right.
    typedef struct {
        logic [1:0]  op;
        int          n;
        logic [63:0] dat;
        logic [7:0]  exp_data;
        int          exp_beats;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one beat at a negedge, wait for in_ready, return at the negedge after the handshake.
    task automatic drive_beat(input logic [1:0] o, input logic [7:0] d, input logic l);
        int guard;
        guard    = 0;
        op       = o;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        op       = 2'($urandom);
    endtask

    task automatic run_burst(input logic [1:0] o_first, input logic [1:0] o_rest,
                             input logic [63:0] dat, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_beat((k == 0) ? o_first : o_rest, dat[63-8*k -: 8], k == n - 1);
        end
    endtask

    task automatic check_result(input string nm, input logic [7:0] ed, input int eb, input logic eo);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_data"}, 32'(out_data), 32'(ed));
        chk({nm, "_beats"}, 32'(out_beats), 32'(eb));
        chk({nm, "_ovf"}, 32'(out_overflow), 32'(eo));
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic consume(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_valid_after"}, 32'(out_valid), 32'd0);
        chk({nm, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    // Reference: fold the first min(n, MAX_BEATS) beats; NAND is the inverted AND of the kept beats.
    function automatic void ref_model(input logic [1:0] o, input logic [63:0] dat, input int n,
                                      output logic [7:0] rd, output int rb, output logic ro);
        logic [7:0] b;
        rb = (n > MAX_BEATS) ? MAX_BEATS : n;
        ro = (n > MAX_BEATS);
        rd = dat[63 -: 8];
        for (int k = 1; k < rb; k++) begin
            b = dat[63-8*k -: 8];
            case (o)
                2'd1:    rd = rd | b;
                2'd2:    rd = rd ^ b;
                default: rd = rd & b;
            endcase
        end
        if (o == 2'd3) rd = ~rd;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [1:0]  ro_op;
        logic [63:0] rdat;
        int          rn;
        logic [7:0]  md;
        int          mb;
        logic        mo;

        vecs[0] = '{op: 2'd0, n: 1, dat: 64'hA500000000000000, exp_data: 8'hA5, exp_beats: 1, exp_ovf: 1'b0};
        vecs[1] = '{op: 2'd0, n: 3, dat: 64'hF03CFF0000000000, exp_data: 8'h30, exp_beats: 3, exp_ovf: 1'b0};
        vecs[2] = '{op: 2'd2, n: 2, dat: 64'h0FF0000000000000, exp_data: 8'hFF, exp_beats: 2, exp_ovf: 1'b0};
        vecs[3] = '{op: 2'd1, n: 2, dat: 64'h0180000000000000, exp_data: 8'h81, exp_beats: 2, exp_ovf: 1'b0};
        vecs[4] = '{op: 2'd3, n: 2, dat: 64'hFFFF000000000000, exp_data: 8'h00, exp_beats: 2, exp_ovf: 1'b0};
        vecs[5] = '{op: 2'd3, n: 2, dat: 64'hF00F000000000000, exp_data: 8'hFF, exp_beats: 2, exp_ovf: 1'b0};
        vecs[6] = '{op: 2'd0, n: 6, dat: 64'h113377FF00000000, exp_data: 8'h11, exp_beats: 4, exp_ovf: 1'b1};
        vecs[7] = '{op: 2'd0, n: 4, dat: 64'h113377FF00000000, exp_data: 8'h11, exp_beats: 4, exp_ovf: 1'b0};
        vecs[8] = '{op: 2'd1, n: 4, dat: 64'h0102040800000000, exp_data: 8'h0F, exp_beats: 4, exp_ovf: 1'b0};
        vecs[9] = '{op: 2'd2, n: 5, dat: 64'h0102040810000000, exp_data: 8'h0F, exp_beats: 4, exp_ovf: 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_beats", 32'(out_beats), 32'd0);
        chk("rst_out_ovf", 32'(out_overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_burst(vecs[i].op, vecs[i].op, vecs[i].dat, vecs[i].n, 1'b0);
            check_result($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_beats, vecs[i].exp_ovf);
            consume($sformatf("vec%0d", i));
        end

        // Op flipped to XOR on beat 2 must be ignored
        run_burst(2'd3, 2'd2, 64'hFFFF000000000000, 2, 1'b0);
        check_result("op_flip", 8'h00, 2, 1'b0);
        consume("op_flip");

        // Idle gaps mid-burst give the same result
        run_burst(2'd0, 2'd0, 64'hF03CFF0000000000, 3, 1'b1);
        check_result("gaps", 8'h30, 3, 1'b0);
        consume("gaps");

        // Result held under backpressure; beats offered meanwhile are not taken
        run_burst(2'd0, 2'd0, 64'hF03CFF0000000000, 3, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h00;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_result($sformatf("hold%0d", c), 8'h30, 3, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_result("hold_end", 8'h30, 3, 1'b0);
        consume("hold");

        // Reset mid-burst
        drive_beat(2'd1, 8'h55, 1'b0);
        drive_beat(2'd1, 8'h55, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_beats", 32'(out_beats), 32'd0);
        chk("midrst_ovf", 32'(out_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        run_burst(2'd1, 2'd1, 64'h0A00000000000000, 1, 1'b0);
        check_result("post_rst", 8'h0A, 1, 1'b0);
        consume("post_rst");

        // Reset while a result is pending
        run_burst(2'd2, 2'd2, 64'h0F00000000000000, 1, 1'b0);
        check_result("pre_done_rst", 8'h0F, 1, 1'b0);
        rst = 1'b1;
        #1;
        chk("done_rst_valid", 32'(out_valid), 32'd0);
        chk("done_rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("done_rst_no_pulse", 32'(out_valid), 32'd0);

        // Randomized bursts against the reference model
        for (int r = 0; r < 40; r++) begin
            ro_op = 2'($urandom_range(0, 3));
            rn    = int'($urandom_range(1, 7));
            rdat  = {$urandom, $urandom};
            run_burst(ro_op, 2'($urandom_range(0, 3)), rdat, rn, 1'b1);
            ref_model(ro_op, rdat, rn, md, mb, mo);
            check_result($sformatf("rnd%0d", r), md, mb, mo);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            consume($sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
